// File: rtl/button_debounce.sv
// Push-button debouncer: 4-state FSM that accepts a new level only after it has been stable for CNT_MAX cycles.
// Optional two-flop input synchronizer enabled by defining DEBOUNCE_SYNC_EN.
module button_debounce #(
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = $clog2(CNT_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic button_db,
  output logic busy
);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_STAGES = 2;
  logic [SYNC_STAGES-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= button;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s = sync_reg[SYNC_STAGES-1];
`else
  assign s = button;
`endif

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             db_reg, db_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    db_next    = db_reg;
    case (state_reg)
      IDLE_LO: begin
        if (s) begin
          state_next = WAIT_HI;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      WAIT_HI: begin
        // A single sample back at the accepted level aborts the candidate.
        if (!s) begin
          state_next = IDLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_HI;
          db_next    = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_next = WAIT_LO;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_next = IDLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_LO;
          db_next    = 1'b0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE_LO;
        cnt_next   = '0;
        db_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE_LO;
      cnt_reg   <= '0;
      db_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      db_reg    <= db_next;
    end
  end

  assign button_db = db_reg;
  assign busy      = (state_reg == WAIT_HI) || (state_reg == WAIT_LO);

endmodule

// File: tb/tb_button_debounce.sv
// Directed, table-driven bench for button_debounce with CNT_MAX=4.
// Expected rows are written against the sampled input s; the sync delay D shifts them in time.
module tb_button_debounce;

  localparam int CNT_MAX = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int LAT = D + CNT_MAX;

  logic clk = 1'b0;
  logic rst;
  logic button;
  logic button_db;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string name;
    logic  rst;
    logic  button;
    logic  exp_db;
    logic  exp_busy;
  } vec_t;

  vec_t vecs[$];
  logic last_db;
  logic last_busy;

  button_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .button_db (button_db),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Rows in s-time; the first D output samples keep the previous steady values.
  task automatic add_seq(input string name, input string btn, input string db, input string bsy);
    int n;
    int k;
    vec_t v;
    n = btn.len();
    for (int i = 0; i < n + D; i++) begin
      k = i - D;
      v.name     = $sformatf("%s[%0d]", name, i);
      v.rst      = 1'b0;
      v.button   = (i < n) ? (btn[i] == "1") : (btn[n-1] == "1");
      v.exp_db   = (k < 0) ? last_db   : (db[k] == "1");
      v.exp_busy = (k < 0) ? last_busy : (bsy[k] == "1");
      vecs.push_back(v);
    end
    last_db   = (db[n-1] == "1");
    last_busy = (bsy[n-1] == "1");
  endtask

  task automatic step(input logic r, input logic b);
    rst    = r;
    button = b;
    @(posedge clk);
    #1;
  endtask

  // Holds button high from a settled low state and measures edges until button_db rises.
  task automatic measure_rise(input string name);
    int edge_at;
    edge_at = -1;
    for (int i = 1; i <= 40 && edge_at < 0; i++) begin
      step(1'b0, 1'b1);
      if (button_db === 1'b1) edge_at = i;
    end
    check_int(name, edge_at, LAT);
  endtask

  initial begin
    vec_t v;
    rst    = 1'b1;
    button = 1'b0;

    v.name = "reset0"; v.rst = 1'b1; v.button = 1'b0; v.exp_db = 1'b0; v.exp_busy = 1'b0;
    vecs.push_back(v);
    v.name = "reset1";
    vecs.push_back(v);
    last_db   = 1'b0;
    last_busy = 1'b0;

    add_seq("idle_low",   "00000000000000000000", "00000000000000000000", "00000000000000000000");
    add_seq("rise",       "1111111",    "0001111",    "1110000");
    add_seq("fall",       "0000000",    "1110000",    "1110000");
    add_seq("glitch_hi3", "1110000",    "0000000",    "1110000");
    add_seq("rise_again", "1111111",    "0001111",    "1110000");
    add_seq("fall_glitch","0001000000", "1111111000", "1110111000");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].button);
      check({vecs[i].name, ".db"},   button_db, vecs[i].exp_db);
      check({vecs[i].name, ".busy"}, busy,      vecs[i].exp_busy);
    end

    // Reset while WAIT_HI holds cnt=2: partial count must be discarded.
    for (int i = 0; i < D + 2; i++) step(1'b0, 1'b1);
    check("pre_rst_wait.busy", busy, 1'b1);
    check("pre_rst_wait.db", button_db, 1'b0);
    step(1'b1, 1'b1);
    check("rst_mid_wait.db", button_db, 1'b0);
    check("rst_mid_wait.busy", busy, 1'b0);
    measure_rise("rise_after_rst_wait");

    // Reset from IDLE_HI with the button still held.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check("hold_high.db", button_db, 1'b1);
    step(1'b1, 1'b1);
    check("rst_idle_hi.db", button_db, 1'b0);
    check("rst_idle_hi.busy", busy, 1'b0);
    measure_rise("rise_after_rst_hi");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
